wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the pipeline writeback stream (output of the
//  M/WB pipeline register) and a long-latency unit (divider / miss-return path) result stream.
//  The pipeline always has priority. LL results are buffered in an in-order FIFO and drained into free slots.
//  A starvation counter requests a one-slot pipeline bubble when the FIFO is blocked too long.

---
 rtl/wb_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter: pipeline priority, in-order LL result FIFO, starvation stall
// Optional direct LL-to-write-port bypass when the FIFO is empty: define WB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               pipe_rd_addr,
    input  logic [31:0]              pipe_rd,
    input  logic                     pipe_wb_en,
    input  logic                     ll_valid,
    output logic                     ll_ready,
    input  logic [4:0]               ll_rd_addr,
    input  logic [31:0]              ll_rd,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   ll_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIMIT_C  = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_STALL
    } state_t;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          slot_busy;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          bypass;
    logic          blocked;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_inc;

    // A pipeline write to x0 is a no-op, so it leaves the slot free for the FIFO.
    assign slot_busy  = pipe_wb_en && (pipe_rd_addr != 5'd0);
    assign fifo_empty = (ll_pending == '0);
    assign ll_ready   = (ll_pending != FULL_CNT);
    assign pop        = !slot_busy && !fifo_empty;
    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign blocked    = !fifo_empty && slot_busy;

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && !slot_busy && ll_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = ll_valid && ll_ready && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= ll_rd_addr;
            mem_data[wr_ptr] <= ll_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ll_pending <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   ll_pending <= ll_pending + (PW + 1)'(1);
                2'b01:   ll_pending <= ll_pending - (PW + 1)'(1);
                default: ll_pending <= ll_pending;
            endcase
        end
    end

    // Address/data only change on a real write so they hold across idle and dropped-x0 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (slot_busy) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_rd_addr;
            rf_wdata <= pipe_rd;
        end else if (pop) begin
            rf_we <= (head_addr != 5'd0);
            if (head_addr != 5'd0) begin
                rf_waddr <= head_addr;
                rf_wdata <= head_data;
            end
        end else if (bypass) begin
            rf_we <= (ll_rd_addr != 5'd0);
            if (ll_rd_addr != 5'd0) begin
                rf_waddr <= ll_rd_addr;
                rf_wdata <= ll_rd;
            end
        end else begin
            rf_we <= 1'b0;
        end
    end

    assign starve_cnt_inc = starve_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (blocked) begin
                        starve_cnt <= CW'(1);
                        if (CW'(1) == LIMIT_C) begin
                            state     <= S_STALL;
                            stall_req <= 1'b1;
                        end else begin
                            state <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (blocked) begin
                        starve_cnt <= starve_cnt_inc;
                        if (starve_cnt_inc == LIMIT_C) begin
                            state     <= S_STALL;
                            stall_req <= 1'b1;
                        end
                    end else begin
                        state      <= S_IDLE;
                        starve_cnt <= '0;
                    end
                end
                S_STALL: begin
                    if (pop || fifo_empty) begin
                        state      <= S_IDLE;
                        starve_cnt <= '0;
                        stall_req  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    starve_cnt <= '0;
                    stall_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8)
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd;
    logic        pipe_wb_en;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd_addr;
    logic [31:0] ll_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [2:0]  ll_pending;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t ll_q[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_rd_addr(pipe_rd_addr), .pipe_rd(pipe_rd), .pipe_wb_en(pipe_wb_en),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd_addr(ll_rd_addr), .ll_rd(ll_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .ll_pending(ll_pending)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pipe_wb_en   = 1'b0;
        pipe_rd_addr = 5'd0;
        pipe_rd      = 32'd0;
        ll_valid     = 1'b0;
        ll_rd_addr   = 5'd0;
        ll_rd        = 32'd0;
    endtask

    task automatic test_reset;
        pipe_wb_en   = 1'b1;
        pipe_rd_addr = 5'd1;
        pipe_rd      = 32'h1;
        for (int i = 0; i < 3; i++) begin
            ll_valid   = 1'b1;
            ll_rd_addr = 5'(i + 1);
            ll_rd      = 32'(i);
            tick();
        end
        ll_valid = 1'b0;
        tests++; if (ll_pending !== 3'd3) begin fails++; $display("FAIL rst_prefill pending got %0d want 3", ll_pending); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we got %0b want 0", rf_we); end
        tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin fails++; $display("FAIL rst_addr_data got %0d/%h want 0/0", rf_waddr, rf_wdata); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_stall got %0b want 0", stall_req); end
        tests++; if (ll_pending !== 3'd0) begin fails++; $display("FAIL rst_pending got %0d want 0", ll_pending); end
        tests++; if (ll_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0b want 1", ll_ready); end
        tick();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_discard got we=%0b want 0", rf_we); end
    endtask

    task automatic test_pipe_write;
        pipe_wb_en   = 1'b1;
        pipe_rd_addr = 5'd5;
        pipe_rd      = 32'hDEADBEEF;
        tick();
        tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL pipe_write got %0b/%0d/%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        pipe_rd_addr = 5'd0;
        pipe_rd      = 32'h1234;
        tick();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL pipe_x0 got we=%0b want 0", rf_we); end
        tests++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL pipe_hold got %0d/%h want 5/deadbeef", rf_waddr, rf_wdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ll_latency;
        ll_valid   = 1'b1;
        ll_rd_addr = 5'd7;
        ll_rd      = 32'h11;
        tick();
        ll_valid = 1'b0;
`ifdef WB_BYPASS_EN
        tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin
            fails++; $display("FAIL ll_bypass got %0b/%0d/%h want 1/7/11", rf_we, rf_waddr, rf_wdata);
        end
        tests++; if (ll_pending !== 3'd0) begin fails++; $display("FAIL ll_bypass_pending got %0d want 0", ll_pending); end
`else
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL ll_t1 got we=%0b want 0", rf_we); end
        tests++; if (ll_pending !== 3'd1) begin fails++; $display("FAIL ll_t1_pending got %0d want 1", ll_pending); end
        tick();
        tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin
            fails++; $display("FAIL ll_t2 got %0b/%0d/%h want 1/7/11", rf_we, rf_waddr, rf_wdata);
        end
`endif
        tick();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL ll_after got we=%0b want 0", rf_we); end
    endtask

    task automatic test_fifo_full;
        ent_t e;
        ll_q.delete();
        pipe_wb_en   = 1'b1;
        pipe_rd_addr = 5'd3;
        for (int i = 0; i < 5; i++) begin
            pipe_rd    = 32'h300 + 32'(i);
            ll_valid   = 1'b1;
            ll_rd_addr = 5'(10 + i);
            ll_rd      = 32'h100 + 32'(i);
            tests++; if (ll_ready !== (i < 4)) begin fails++; $display("FAIL full_ready%0d got %0b want %0b", i, ll_ready, (i < 4)); end
            if (ll_ready === 1'b1) ll_q.push_back({ll_rd_addr, ll_rd});
            tick();
            tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h300 + 32'(i)) begin
                fails++; $display("FAIL full_pipe%0d got %0b/%0d/%h want 1/3/%h", i, rf_we, rf_waddr, rf_wdata, 32'h300 + 32'(i));
            end
        end
        tests++; if (ll_pending !== 3'd4 || ll_ready !== 1'b0) begin
            fails++; $display("FAIL full_state got pending=%0d ready=%0b want 4/0", ll_pending, ll_ready);
        end
        pipe_wb_en = 1'b0;
        tick();
        e = ll_q.pop_front();
        tests++; if (rf_we !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
            fails++; $display("FAIL drain0 got %0b/%0d/%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        tests++; if (ll_ready !== 1'b1 || ll_pending !== 3'd3) begin
            fails++; $display("FAIL drain0_state got ready=%0b pending=%0d want 1/3", ll_ready, ll_pending);
        end
        if (ll_ready === 1'b1) ll_q.push_back({ll_rd_addr, ll_rd});
        tick();
        ll_valid = 1'b0;
        e = ll_q.pop_front();
        tests++; if (rf_we !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
            fails++; $display("FAIL drain1 got %0b/%0d/%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
        end
        tests++; if (ll_pending !== 3'd3) begin fails++; $display("FAIL pushpop_pending got %0d want 3", ll_pending); end
        for (int k = 0; k < 8 && ll_q.size() > 0; k++) begin
            tick();
            e = ll_q.pop_front();
            tests++; if (rf_we !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
                fails++; $display("FAIL drain_order got %0b/%0d/%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
            end
        end
        tests++; if (ll_pending !== 3'd0) begin fails++; $display("FAIL drain_empty got %0d want 0", ll_pending); end
        tick();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL drain_idle got we=%0b want 0", rf_we); end
    endtask

    task automatic test_starvation;
        ent_t e;
        ll_q.delete();
        pipe_wb_en   = 1'b1;
        pipe_rd_addr = 5'd4;
        pipe_rd      = 32'h44;
        ll_valid     = 1'b1;
        ll_rd_addr   = 5'd20;
        ll_rd        = 32'hABC;
        if (ll_ready === 1'b1) ll_q.push_back({ll_rd_addr, ll_rd});
        tick();
        ll_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++; if (stall_req !== (k == 8)) begin
                fails++; $display("FAIL starve_cycle%0d got stall=%0b want %0b", k, stall_req, (k == 8));
            end
        end
        tick();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL starve_hold got %0b want 1", stall_req); end
        pipe_wb_en = 1'b0;
        tick();
        tests++; if (ll_q.size() != 1) begin fails++; $display("FAIL starve_sb got %0d entries want 1", ll_q.size()); end
        if (ll_q.size() > 0) begin
            e = ll_q.pop_front();
            tests++; if (rf_we !== 1'b1 || rf_waddr !== e.a || rf_wdata !== e.d) begin
                fails++; $display("FAIL starve_drain got %0b/%0d/%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.a, e.d);
            end
        end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_release got %0b want 0", stall_req); end
        tests++; if (ll_pending !== 3'd0) begin fails++; $display("FAIL starve_pending got %0d want 0", ll_pending); end
    endtask

    task automatic test_x0_slot;
        ent_t e;
        ent_t stim [3];
        stim[0] = {5'd9, 32'h99};
        stim[1] = {5'd0, 32'h55};
        stim[2] = {5'd12, 32'hCC};
        ll_q.delete();
        pipe_wb_en   = 1'b1;
        pipe_rd_addr = 5'd2;
        pipe_rd      = 32'h22;
        for (int i = 0; i < 3; i++) begin
            ll_valid   = 1'b1;
            ll_rd_addr = stim[i].a;
            ll_rd      = stim[i].d;
            if (ll_ready === 1'b1) ll_q.push_back(stim[i]);
            tick();
        end
        ll_valid     = 1'b0;
        pipe_rd_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ll_q.size() == 0) begin
                tests++; fails++; $display("FAIL x0_sb got empty want entry %0d", i);
            end else begin
                e = ll_q.pop_front();
                tests++; if (rf_we !== (e.a != 5'd0)) begin
                    fails++; $display("FAIL x0_we%0d got %0b want %0b", i, rf_we, (e.a != 5'd0));
                end
                if (e.a != 5'd0) begin
                    tests++; if (rf_waddr !== e.a || rf_wdata !== e.d) begin
                        fails++; $display("FAIL x0_data%0d got %0d/%h want %0d/%h", i, rf_waddr, rf_wdata, e.a, e.d);
                    end
                end else begin
                    tests++; if (rf_waddr !== 5'd9) begin
                        fails++; $display("FAIL x0_drop_hold got %0d want 9", rf_waddr);
                    end
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_pipe_write();
        test_ll_latency();
        test_fifo_full();
        test_starvation();
        test_x0_slot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
